// File: rtl/parking_pkg.sv
// parking_pkg: key codes, debounce state encoding and password width shared with the gate controller
package parking_pkg;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int PW_WIDTH = 8;
  typedef enum logic [1:0] {RELEASED, PRESSING, HELD, RELEASING} db_state_t;
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: turns a raw key-down level into exactly one registered event per stable press
module keypad_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_event_code
);
  localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES);
  db_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] code_n;
  logic ev_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RELEASED;
      cnt <= '0;
      key_event_code <= '0;
      key_event <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      key_event_code <= code_n;
      key_event <= ev_n;
    end
  // the sample that causes a state change counts as the first of its run
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    code_n = key_event_code;
    ev_n = 1'b0;
    case (state)
      RELEASED:
        if (key_valid) begin
          state_n = PRESSING;
          cnt_n = 8'd1;
          code_n = key_code;
        end
      PRESSING:
        if (!key_valid) begin
          state_n = RELEASED;
          cnt_n = '0;
        end else if (key_code != key_event_code) begin
          code_n = key_code;
          cnt_n = 8'd1;
        end else if (cnt + 8'd1 == LIM) begin
          state_n = HELD;
          cnt_n = '0;
          ev_n = 1'b1;
        end else cnt_n = cnt + 8'd1;
      HELD:
        if (!key_valid) begin
          state_n = RELEASING;
          cnt_n = 8'd1;
        end
      RELEASING:
        if (key_valid) begin
          state_n = HELD;
          cnt_n = '0;
        end else if (cnt + 8'd1 == LIM) begin
          state_n = RELEASED;
          cnt_n = '0;
        end else cnt_n = cnt + 8'd1;
      default: state_n = RELEASED;
    endcase
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced keypad to 3-digit decimal password attempts for the gate controller
module keypad_entry
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_DIGITS      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                entry_en,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [PW_WIDTH-1:0] psswrd_atmpt,
  output logic                try_pssrd,
  output logic [1:0]          digit_count,
  output logic                entry_err,
  output logic                entry_timeout
);
  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES);
  logic key_event;
  logic [3:0] ev_code;
  logic [9:0] acc, acc_next;
  logic [15:0] idle;
  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_event(key_event),
    .key_event_code(ev_code)
  );
  // 10-bit accumulator holds up to 999 so oversize entries are caught before truncation
  assign acc_next = (acc << 3) + (acc << 1) + {6'd0, ev_code};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      idle <= '0;
      digit_count <= '0;
      psswrd_atmpt <= '0;
      try_pssrd <= 1'b0;
      entry_err <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      try_pssrd <= 1'b0;
      entry_err <= 1'b0;
      entry_timeout <= 1'b0;
      if (!entry_en) begin
        acc <= '0;
        digit_count <= '0;
        idle <= '0;
      end else if (key_event) begin
        idle <= '0;
        if (ev_code <= 4'd9) begin
          if (digit_count == MAXD) entry_err <= 1'b1;
          else begin
            acc <= acc_next;
            digit_count <= digit_count + 2'd1;
          end
        end else if (ev_code == KEY_CLEAR) begin
          acc <= '0;
          digit_count <= '0;
        end else if (ev_code == KEY_ENTER) begin
          if (digit_count == 2'd0) entry_err <= 1'b1;
          else begin
            acc <= '0;
            digit_count <= '0;
            if (acc > 10'd255) entry_err <= 1'b1;
            else begin
              psswrd_atmpt <= acc[7:0];
              try_pssrd <= 1'b1;
            end
          end
        end
      end else if (digit_count != 2'd0) begin
        if (idle + 16'd1 == TLIM) begin
          acc <= '0;
          digit_count <= '0;
          idle <= '0;
          entry_timeout <= 1'b1;
        end else idle <= idle + 16'd1;
      end else idle <= '0;
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: random and directed key presses scored against a per-press entry model
module tb_keypad_entry;
  import parking_pkg::*;
  localparam int D = 4;
  localparam int T = 20;
  logic clk = 1'b0, rst = 1'b1, entry_en = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] psswrd_atmpt;
  logic try_pssrd, entry_err, entry_timeout;
  logic [1:0] digit_count;

  keypad_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .entry_en(entry_en), .key_valid(key_valid), .key_code(key_code),
    .psswrd_atmpt(psswrd_atmpt), .try_pssrd(try_pssrd), .digit_count(digit_count),
    .entry_err(entry_err), .entry_timeout(entry_timeout)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 strobe, 1 error, 2 timeout; at: edge after which the pulse is visible
  typedef struct {int kind; int val; int at;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int m_acc = 0, m_dc = 0, m_pw = 0, m_last = 0;
  bit m_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(int kind, int at);
    sb.push_back('{kind, m_pw, at});
  endfunction

  // a partial entry expires T cycles after the last processed key unless another key is processed first
  function automatic void expire(int upto);
    if (m_en && m_dc > 0 && m_last + T < upto) begin
      push(2, m_last + T);
      m_acc = 0;
      m_dc = 0;
    end
  endfunction

  function automatic void apply(int code, int p);
    expire(p);
    if (!m_en) return;
    m_last = p;
    if (code < 10) begin
      if (m_dc < 3) begin
        m_acc = m_acc * 10 + code;
        m_dc++;
      end else push(1, p);
    end else if (code == 10) begin
      m_acc = 0;
      m_dc = 0;
    end else if (code == 11) begin
      if (m_dc == 0) push(1, p);
      else begin
        if (m_acc > 255) push(1, p);
        else begin
          m_pw = m_acc;
          push(0, p);
        end
        m_acc = 0;
        m_dc = 0;
      end
    end
  endfunction

  task automatic press(input int code, input int hold, input int rel);
    int c1;
    c1 = cyc + 1;
    if (hold >= D) apply(code, c1 + D);
    expire(c1 + hold + rel);
    key_code = 4'(code);
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (rel) @(negedge clk);
    check("digit_count", digit_count, m_dc);
  endtask

  task automatic press_chg(input int a, input int na, input int b, input int nb, input int rel);
    int c1;
    c1 = cyc + 1;
    if (nb >= D) apply(b, c1 + na + D);
    expire(c1 + na + nb + rel);
    key_code = 4'(a);
    key_valid = 1'b1;
    repeat (na) @(negedge clk);
    key_code = 4'(b);
    repeat (nb) @(negedge clk);
    key_valid = 1'b0;
    repeat (rel) @(negedge clk);
    check("digit_count_chg", digit_count, m_dc);
  endtask

  task automatic idle(input int n);
    expire(cyc + n + 1);
    repeat (n) @(negedge clk);
    check("digit_count_idle", digit_count, m_dc);
  endtask

  task automatic set_en(input bit v);
    entry_en = v;
    m_en = v;
    if (!v) begin
      m_acc = 0;
      m_dc = 0;
    end
  endtask

  always @(negedge clk)
    if (!rst && (try_pssrd || entry_err || entry_timeout)) begin
      exp_t e;
      check("one_pulse", 32'(try_pssrd) + 32'(entry_err) + 32'(entry_timeout), 1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got try=%0b err=%0b timeout=%0b at cycle %0d, expected none",
                 try_pssrd, entry_err, entry_timeout, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", try_pssrd ? 0 : entry_err ? 1 : 2, e.kind);
        check("pulse_cycle", cyc, e.at);
        check("psswrd_atmpt", psswrd_atmpt, e.val);
      end
    end

  initial begin
    #2;
    check("rst_psswrd", psswrd_atmpt, 0);
    check("rst_try", try_pssrd, 0);
    check("rst_count", digit_count, 0);
    check("rst_err", entry_err, 0);
    check("rst_timeout", entry_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    press(8, 6, 6); press(7, 6, 6); press(11, 6, 6);
    press(2, 6, 6); press(5, 6, 6); press(6, 6, 6); press(11, 6, 6);
    press(1, 6, 6); press(2, 6, 6); press(3, 6, 6); press(4, 6, 6); press(11, 6, 6);
    press(8, 6, 6); idle(30); press(11, 6, 6);
    press(5, 3, 6);
    press_chg(8, 1, 7, 6, 6); press(11, 6, 6);
    press(4, 6, 6); press(11, 50, 6);
    press(9, 6, 6); press(10, 6, 6); press(11, 6, 6);
    press(12, 6, 6); press(15, 6, 6);
    set_en(1'b0); press(1, 6, 6); press(11, 6, 6);
    key_code = 4'd5;
    key_valid = 1'b1;
    repeat (8) @(negedge clk);
    set_en(1'b1);
    repeat (4) @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("held_across_enable", digit_count, 0);
    press(9, 6, 6); press(9, 6, 6);
    check("queue_before_reset", sb.size(), 0);
    #2 rst = 1'b1;
    #1;
    check("async_psswrd", psswrd_atmpt, 0);
    check("async_count", digit_count, 0);
    check("async_try", try_pssrd, 0);
    m_pw = 0;
    m_acc = 0;
    m_dc = 0;
    @(negedge clk);
    rst = 1'b0;
    press(4, 6, 6); press(2, 6, 6); press(11, 6, 6);
    for (int i = 0; i < 60; i++) begin
      int code, hold;
      code = ($urandom_range(0, 3) == 0) ? 11 : int'($urandom_range(0, 15));
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, D - 1)) : int'($urandom_range(D, 8));
      press(code, hold, int'($urandom_range(D, 8)));
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(0, 25)));
    end
    idle(30);
    repeat (5) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Password-entry front end for the parking access controller. Debounces a scanned keypad, accumulates up to three decimal digits into a binary value, and on ENTER delivers `psswrd_atmpt` together with a one-cycle `try_pssrd` strobe to the gate controller FSM directly downstream. Clear, inter-digit timeout, overflow rejection and a car-present enable keep stale or malformed entries from reaching the gate controller.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept a press or a release (range 2-255).
- `TIMEOUT_CYCLES`, default 1000: idle cycles with a partial entry before the entry is discarded (range 2-65535).
- `MAX_DIGITS`, default 3: maximum digits per entry (range 1-3).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `entry_en`  in  1  car present; driven from `sensor_1`. Low clears the entry and ignores keys.
- `key_valid`  in  1  raw key-down level from the scanner.
- `key_code`  in  4  0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC-4'hF ignored.
- `psswrd_atmpt`  out  8  last submitted value; held until the next submit.
- `try_pssrd`  out  1  one-cycle strobe; `psswrd_atmpt` is valid in the same cycle.
- `digit_count`  out  2  digits currently entered, for the display.
- `entry_err`  out  1  one-cycle pulse on a rejected key or entry.
- `entry_timeout`  out  1  one-cycle pulse when a partial entry expires.

## Operation
- Reset values: `psswrd_atmpt`=8'h00, `try_pssrd`=0, `digit_count`=0, `entry_err`=0, `entry_timeout`=0, accumulator=0, FSM in RELEASED, both counters at 0.
- Debounce FSM with states RELEASED, PRESSING, HELD and RELEASING:
  - RELEASED → PRESSING when `key_valid`=1. The current code is latched.
  - PRESSING counts consecutive high samples with an unchanged code. A code change restarts the count at 1. Low → RELEASED.
  - When the count reaches DEBOUNCE_CYCLES, exactly one key event is emitted and the FSM moves to HELD.
  - HELD → RELEASING when `key_valid`=0. RELEASING → RELEASED after DEBOUNCE_CYCLES consecutive low samples. Any high sample in RELEASING returns to HELD.
  - A long press therefore never repeats.
- Entry logic, processed per key event:
  - **Digit d with `digit_count` < MAX_DIGITS:** acc = acc*10 + d, and `digit_count` increments.
  - **Digit with `digit_count` = MAX_DIGITS:** ignored, and `entry_err` pulses.
  - **CLEAR:** acc=0 and `digit_count`=0. No pulse.
  - **ENTER with `digit_count`=0:** `entry_err` pulses. No strobe.
  - **ENTER with acc > 255:** `entry_err` pulses and the entry is cleared. No strobe.
  - **ENTER otherwise:** `psswrd_atmpt` = acc[7:0] and `try_pssrd` pulses. acc and `digit_count` are cleared.
  - **Codes C-F:** ignored silently.
- The accumulator is 10 bits wide (max 999). Compute acc*10 as (acc<<3)+(acc<<1). It is never truncated before the 255 check.
- Timeout:
  - While `digit_count` > 0, the idle counter increments each cycle with no key event and resets on every key event.
  - When it reaches TIMEOUT_CYCLES, the entry is cleared and `entry_timeout` pulses.
- `entry_en`=0 has these effects:
  - acc, `digit_count` and the idle counter are cleared every cycle.
  - Key events are dropped.
  - The debounce FSM keeps running, so a key held across the enable rising edge is not accepted.
  - `psswrd_atmpt` is not cleared.
- Simultaneous events in one cycle:
  - Timeout expiry and a key event: the key event wins, and no timeout pulse is issued.
  - `entry_en` falling and an ENTER event: no strobe.
- Asynchronous reset mid-entry discards everything. No strobe is issued.

## Timing
- If `key_valid` is first sampled high at edge 1 with a stable code, the key event is registered at edge DEBOUNCE_CYCLES. `digit_count`, `psswrd_atmpt`, `try_pssrd` and `entry_err` update at edge DEBOUNCE_CYCLES+1.
- `try_pssrd`, `entry_err` and `entry_timeout` are high for exactly one cycle. They are mutually exclusive.
- Minimum key period: 2*DEBOUNCE_CYCLES+1 cycles.
- The downstream consumer samples `psswrd_atmpt` only while `try_pssrd`=1. There is no backpressure.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `parking_pkg` holds:
  - Key code localparams: KEY_CLEAR=4'hA, KEY_ENTER=4'hB.
  - The debounce state encoding.
  - The 8-bit width constant shared with the gate controller.
- Sub-module `keypad_debounce` contains the debounce FSM and counter.
  - Ports: `clk`, `rst`, `key_valid`, `key_code`, `key_event`, `key_event_code`.
- The top level holds the accumulator, digit counter, idle counter and output registers.

## Test plan
- Keys 8, 7, ENTER, each held 6 and released 6 cycles (DEBOUNCE_CYCLES=4) → a single `try_pssrd` pulse with `psswrd_atmpt`=8'h57. `digit_count` goes 1, 2, then 0.
- Keys 2, 5, 6, ENTER → `entry_err` pulse, no strobe, `digit_count`=0, and `psswrd_atmpt` keeps its previous value.
- Keys 1, 2, 3, 4 → `entry_err` on the fourth digit. A following ENTER strobes 8'h7B (123).
- Key 8 pressed and then idle for TIMEOUT_CYCLES (set to 20) → `entry_timeout` pulse at idle cycle 20 and `digit_count`=0. A following ENTER gives `entry_err`.
- `key_valid` glitching high for 3 cycles, or code changing 8→7 at cycle 2 of a press → no event, or a single event for 7 only. A press held 50 cycles yields exactly one event.
- `rst` asserted asynchronously mid-entry after 9, 9 → all outputs return to zero immediately. `entry_en`=0 during keys 1, ENTER → no strobe.
